// File: rtl/approx_adder_err_monitor.sv
// Mode-selectable approximate adder with a windowed error-statistics engine.
// Sums register one cycle after in_valid; stats accumulate over WINDOW samples after start.
module approx_adder_err_monitor #(
    parameter int          N           = 8,
    parameter int          CARRY_LIMIT = 4,
    parameter int          WINDOW      = 16,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    localparam int         CW          = $clog2(WINDOW + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      mode,
    input  logic            in_valid,
    input  logic [N-1:0]    a,
    input  logic [N-1:0]    b,
    output logic            out_valid,
    output logic [N-1:0]    sum_exact,
    output logic [N-1:0]    sum_approx,
    output logic            busy,
    output logic            done,
    output logic [CW-1:0]   err_count,
    output logic [N+CW-1:0] err_sum,
    output logic [N-1:0]    err_max
);
    localparam int          K    = CARRY_LIMIT;
    localparam int          SEGS = N / K;
    localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic             win_last;
    logic [2:0]       mode_lat;
    logic [15:0]      lfsr;
    logic [15:0]      lfsr_nxt;
    logic [CW-1:0]    cnt;

    logic [2:0]       act_mode_p0;
    logic [N-1:0]     exact_p0;
    logic [N-1:0]     approx_p0;
    logic [N-1:0]     dist_p0;

    logic             vld_p1;
    logic [N-1:0]     sum_exact_p1;
    logic [N-1:0]     sum_approx_p1;

    function automatic logic [N-1:0] approx_sum(input logic [2:0] m,
                                                input logic [N-1:0] x,
                                                input logic [N-1:0] y,
                                                input logic keep_carry);
        logic [N-1:0]   r;
        logic [K:0]     lo_full;
        logic [N-K-1:0] hi;
        r       = x + y;
        lo_full = {1'b0, x[K-1:0]} + {1'b0, y[K-1:0]};
        hi      = x[N-1:K] + y[N-1:K];
        case (m)
            3'd1: r = {hi, {K{1'b0}}};
            3'd2: r = {hi, x[K-1:0] | y[K-1:0]};
            3'd3: begin
                // every segment wraps on its own; inter-segment carries are dropped
                for (int s = 0; s < SEGS; s++)
                    r[s*K +: K] = x[s*K +: K] + y[s*K +: K];
            end
            3'd4: r = {hi + (N-K)'(keep_carry & lo_full[K]), lo_full[K-1:0]};
            default: r = x + y;
        endcase
        return r;
    endfunction

    function automatic logic [N-1:0] err_dist(input logic [N-1:0] e,
                                              input logic [N-1:0] p);
        return (e >= p) ? (e - p) : (p - e);
    endfunction

    // 16-bit Fibonacci, taps 16,14,13,11, shifting toward bit 0
    assign lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

    // ---- stage p0: combinational sums and error distance ----
    assign act_mode_p0 = (state == RUN) ? mode_lat : mode;
    assign exact_p0    = a + b;
    assign approx_p0   = approx_sum(act_mode_p0, a, b, lfsr[0]);
    assign dist_p0     = err_dist(exact_p0, approx_p0);

    always_comb begin
        state_nxt = state;
        win_last  = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                if (in_valid && (cnt == LAST)) begin
                    win_last  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---- stage p1: registered sums, LFSR, FSM and statistics ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            vld_p1        <= 1'b0;
            sum_exact_p1  <= '0;
            sum_approx_p1 <= '0;
            lfsr          <= LFSR_SEED;
            mode_lat      <= 3'd0;
            cnt           <= '0;
            done          <= 1'b0;
            err_count     <= '0;
            err_sum       <= '0;
            err_max       <= '0;
        end else begin
            state  <= state_nxt;
            vld_p1 <= in_valid;
            done   <= win_last;
            if (in_valid) begin
                sum_exact_p1  <= exact_p0;
                sum_approx_p1 <= approx_p0;
                lfsr          <= lfsr_nxt;
            end
            if ((state == IDLE) && start) begin
                mode_lat  <= mode;
                cnt       <= '0;
                err_count <= '0;
                err_sum   <= '0;
                err_max   <= '0;
            end else if ((state == RUN) && in_valid) begin
                cnt       <= cnt + CW'(1);
                err_count <= err_count + CW'(dist_p0 != '0);
                err_sum   <= err_sum + (N+CW)'(dist_p0);
                if (dist_p0 > err_max)
                    err_max <= dist_p0;
            end
        end
    end

    assign out_valid  = vld_p1;
    assign sum_exact  = sum_exact_p1;
    assign sum_approx = sum_approx_p1;
    assign busy       = (state == RUN);

endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// Directed bench for approx_adder_err_monitor (N=8, K=4, WINDOW=4).
// Expected values are hand-computed; stochastic mode uses a bench-side LFSR model.
module tb_approx_adder_err_monitor;
    localparam int N  = 8;
    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);
    localparam logic [15:0] SEED = 16'hACE1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [2:0]      mode;
    logic            in_valid;
    logic [N-1:0]    a, b;
    logic            out_valid;
    logic [N-1:0]    sum_exact, sum_approx;
    logic            busy, done;
    logic [CW-1:0]   err_count;
    logic [N+CW-1:0] err_sum;
    logic [N-1:0]    err_max;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] lfsr_m;
    logic [7:0]  exp_st;

    approx_adder_err_monitor #(.N(N), .CARRY_LIMIT(4), .WINDOW(W), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .in_valid(in_valid),
        .a(a), .b(b), .out_valid(out_valid), .sum_exact(sum_exact), .sum_approx(sum_approx),
        .busy(busy), .done(done), .err_count(err_count), .err_sum(err_sum), .err_max(err_max)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [2:0] m, input logic [7:0] x, input logic [7:0] y);
        mode = m; a = x; b = y; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lfsr_m = lfsr_step(lfsr_m);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ov"},   32'(out_valid),  32'h0);
        chk({tag, "_se"},   32'(sum_exact),  32'h0);
        chk({tag, "_sa"},   32'(sum_approx), 32'h0);
        chk({tag, "_busy"}, 32'(busy),       32'h0);
        chk({tag, "_done"}, 32'(done),       32'h0);
        chk({tag, "_cnt"},  32'(err_count),  32'h0);
        chk({tag, "_sum"},  32'(err_sum),    32'h0);
        chk({tag, "_max"},  32'(err_max),    32'h0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 3'd0; in_valid = 1'b0; a = '0; b = '0;
        lfsr_m = SEED;
        step(); step();
        chk_zero("reset");
        rst_n = 1'b1;
        step();

        // fixed approximation modes in IDLE (live mode)
        sample(3'd1, 8'h1B, 8'h25);
        chk("m1_ov", 32'(out_valid), 32'h1);
        chk("m1_ex", 32'(sum_exact), 32'h40);
        chk("m1_ap", 32'(sum_approx), 32'h30);
        sample(3'd2, 8'h1B, 8'h25);
        chk("m2_ap", 32'(sum_approx), 32'h3F);
        sample(3'd3, 8'h1B, 8'h25);
        chk("m3_ap", 32'(sum_approx), 32'h30);
        step();
        chk("gap_ov", 32'(out_valid), 32'h0);
        sample(3'd1, 8'hF0, 8'h0F);
        chk("f0_ex", 32'(sum_exact), 32'hFF);
        chk("f0_m1", 32'(sum_approx), 32'hF0);
        sample(3'd2, 8'hF0, 8'h0F);
        chk("f0_m2", 32'(sum_approx), 32'hFF);
        sample(3'd3, 8'hF0, 8'h0F);
        chk("f0_m3", 32'(sum_approx), 32'hFF);
        sample(3'd1, 8'hAA, 8'h55);
        chk("aa_m1", 32'(sum_approx), 32'hF0);
        sample(3'd2, 8'hAA, 8'h55);
        chk("aa_m2", 32'(sum_approx), 32'hFF);
        sample(3'd3, 8'hAA, 8'h55);
        chk("aa_m3", 32'(sum_approx), 32'hFF);
        sample(3'd1, 8'hFF, 8'h01);
        chk("wrap_ex", 32'(sum_exact), 32'h00);
        chk("wrap_ap", 32'(sum_approx), 32'hF0);
        sample(3'd5, 8'h1B, 8'h25);
        chk("m5_ap", 32'(sum_approx), 32'h40);
        sample(3'd0, 8'h1B, 8'h25);
        chk("m0_ap", 32'(sum_approx), 32'h40);

        // measurement window; sample in the start cycle (distance 240) must not count
        start = 1'b1;
        sample(3'd1, 8'hFF, 8'h01);
        start = 1'b0;
        chk("win_busy0", 32'(busy), 32'h1);
        chk("win_cnt0", 32'(err_count), 32'h0);
        chk("win_max0", 32'(err_max), 32'h0);
        sample(3'd1, 8'h1B, 8'h25);
        chk("win_cnt1", 32'(err_count), 32'h1);
        chk("win_done1", 32'(done), 32'h0);
        start = 1'b1;
        sample(3'd1, 8'hF0, 8'h0F);
        start = 1'b0;
        chk("win_sum2", 32'(err_sum), 32'd31);
        chk("win_busy2", 32'(busy), 32'h1);
        step();
        chk("win_gap_ov", 32'(out_valid), 32'h0);
        chk("win_gap_busy", 32'(busy), 32'h1);
        chk("win_gap_done", 32'(done), 32'h0);
        sample(3'd0, 8'hAA, 8'h55);
        chk("win_latched_ap", 32'(sum_approx), 32'hF0);
        chk("win_done3", 32'(done), 32'h0);
        chk("win_busy3", 32'(busy), 32'h1);
        sample(3'd0, 8'h10, 8'h20);
        chk("win_done4", 32'(done), 32'h1);
        chk("win_busy4", 32'(busy), 32'h0);
        chk("win_cnt", 32'(err_count), 32'd3);
        chk("win_sum", 32'(err_sum), 32'd46);
        chk("win_max", 32'(err_max), 32'd16);
        step();
        chk("hold_done", 32'(done), 32'h0);
        chk("hold_cnt", 32'(err_count), 32'd3);
        chk("hold_sum", 32'(err_sum), 32'd46);
        chk("hold_max", 32'(err_max), 32'd16);

        // reset mid-window
        mode = 3'd1; start = 1'b1;
        step();
        start = 1'b0;
        sample(3'd1, 8'h1B, 8'h25);
        sample(3'd1, 8'hF0, 8'h0F);
        chk("pre_rst_cnt", 32'(err_count), 32'd2);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        step();
        rst_n = 1'b1;
        lfsr_m = SEED;
        step();
        chk("post_rst_done", 32'(done), 32'h0);
        chk("post_rst_busy", 32'(busy), 32'h0);

        // reseeded LFSR: seed bit0 = 1 keeps the carry
        sample(3'd4, 8'h1B, 8'h25);
        chk("st_seed", 32'(sum_approx), 32'h40);

        // fresh window completes normally
        mode = 3'd1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            chk("fresh_nodone", 32'(done), 32'h0);
            sample(3'd1, 8'h1B, 8'h25);
        end
        chk("fresh_done", 32'(done), 32'h1);
        chk("fresh_cnt", 32'(err_count), 32'd4);
        chk("fresh_sum", 32'(err_sum), 32'd64);
        chk("fresh_max", 32'(err_max), 32'd16);

        // stochastic mode against the reference LFSR
        for (int i = 0; i < 32; i++) begin
            exp_st = lfsr_m[0] ? 8'h40 : 8'h30;
            sample(3'd4, 8'h1B, 8'h25);
            chk("stoch_ap", 32'(sum_approx), 32'(exp_st));
        end
        chk("stoch_ex", 32'(sum_exact), 32'h40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/approx_adder_err_monitor.md
Name: approx_adder_err_monitor

Overview:
- Parametrised, mode-selectable approximate adder with an error-statistics engine.
- Each accepted operand pair produces an exact sum and an approximate sum, registered with one cycle of latency.
- Over a start-triggered window of WINDOW samples, the block accumulates error count, error sum and maximum error distance against the exact result.
- Used for on-chip characterisation of approximate-adder accuracy, replacing printf-style comparison in simulation.

Parameters:
- N, 8, operand and sum width.
- CARRY_LIMIT, 4, approximate lower-part / segment width K; N must be a multiple of K, with K < N.
- WINDOW, 16, samples per measurement window; must be ≥ 1.
- LFSR_SEED, 16'hACE1, stochastic-mode LFSR reset value; must be nonzero.
- Localparam CW = $clog2(WINDOW+1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begins a measurement window when idle
- mode  in  3  approximation mode; latched at start for the statistics path
- in_valid  in  1  a/b valid this cycle; always accepted, no backpressure
- a  in  N  operand A
- b  in  N  operand B
- out_valid  out  1  sums valid, one cycle after in_valid
- sum_exact  out  N  (a+b) mod 2^N
- sum_approx  out  N  approximate sum under the active mode
- busy  out  1  high while the window is running
- done  out  1  one-cycle pulse when the window completes
- err_count  out  CW  samples whose approximate sum differs from the exact sum
- err_sum  out  N+CW  sum of error distances
- err_max  out  N  maximum error distance

Behaviour:
- Reset is asynchronous, active-low, and overrides all other inputs. On reset:
  - all outputs 0;
  - FSM = IDLE;
  - LFSR = LFSR_SEED;
  - latched mode = 0.
- Modes (K = CARRY_LIMIT; lo = bits [K-1:0], hi = bits [N-1:K]):
  - 0 exact: (a+b) mod 2^N.
  - 1 truncated: lo = 0; hi = a_hi + b_hi, no carry from lo.
  - 2 simplified: lo = a_lo | b_lo; hi = a_hi + b_hi, no carry.
  - 3 reduced-carry: each K-bit segment = a_seg + b_seg mod 2^K; every inter-segment carry is dropped.
  - 4 stochastic: exact lo; carry out of lo into hi is kept only when lfsr[0] = 1, otherwise dropped.
  - 5–7: treated as exact.
- All hi-part additions wrap modulo 2^(N-K).
- sum_approx uses the live mode input while the FSM is IDLE and the latched mode while it is RUN.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances one step on every in_valid cycle, in any state. The carry decision uses the value held before the step.
- Datapath: on the edge after in_valid = 1, the block registers sum_exact and sum_approx and sets out_valid = 1. out_valid = 0 on the edge after a cycle with in_valid = 0.
- Error distance = |sum_exact − sum_approx|, both taken as N-bit unsigned values.
- FSM:
  - IDLE: start = 1 → clear err_count, err_sum, err_max and the sample counter; latch mode; go to RUN with busy = 1.
  - A sample presented in the same cycle as start is not counted.
  - RUN: each in_valid sample updates the stats on the same edge as its sums register:
    - err_count += (dist != 0);
    - err_sum += dist;
    - err_max = max(err_max, dist);
    - sample counter += 1.
  - On the edge that registers the WINDOW-th sample, go to IDLE with busy = 0 and done = 1 for exactly one cycle.
  - start during RUN is ignored. Mode changes during RUN do not affect the statistics.
- Stats hold their values in IDLE until the next start.
- err_sum cannot overflow by construction.
- in_valid gaps during RUN stall the counter only; the window completes on the WINDOW-th valid sample however many cycles that takes.
- Reset mid-window: stats cleared, no done pulse.

Test Plan:
- Defaults N=8, K=4. Mode 1, a=0x1B, b=0x25 → next cycle sum_exact=0x40, sum_approx=0x30, out_valid=1. Mode 2, same operands → sum_approx=0x3F. Mode 3 → 0x30.
- Modes 1/2/3 with a=0xF0, b=0x0F → exact 0xFF, approx 0xF0 / 0xFF / 0xFF. With a=0xAA, b=0x55 → approx 0xF0 / 0xFF / 0xFF.
- Wrap-around: mode 1, a=0xFF, b=0x01 → exact 0x00, approx 0xF0, distance 240.
- WINDOW=4, mode 1, start, then samples (0x1B,0x25), (0xF0,0x0F), (0xAA,0x55), (0x10,0x20) with one idle cycle after the 2nd sample.
  - done pulses once, on the edge after the 4th sample; busy is high throughout the window.
  - err_count=3, err_sum=46, err_max=16; the values hold after done.
  - start asserted mid-window → ignored. Mode switched to 0 mid-window → statistics unchanged.
- Stochastic: mode 4, a=0x1B, b=0x25 with seed 0xACE1 (lfsr[0]=1) → 0x40. Subsequent samples yield 0x30 when the model's lfsr[0]=0. The bench checks against a reference LFSR model across 32 samples.
- Assert rst_n low mid-window after 2 samples → outputs 0, busy=0, no done. A fresh start then completes normally, with the LFSR re-seeded.
